// File: rtl/register_file_pkg.sv
// ============================================================================
// Module   : register_file_pkg
// Brief    : Shared sizes, zero-register index and typedefs for register_file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package register_file_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int ZERO_REG = 31;

  typedef logic [DATA_W-1:0] reg_data_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

`default_nettype wire

// File: rtl/rf_read_port.sv
// ============================================================================
// Module   : rf_read_port
// Brief    : 32:1 combinational read mux with zero-register masking.
//            Optional write-through when REGFILE_BYPASS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_read_port
  import register_file_pkg::*;
#(
  parameter int DATA_W = register_file_pkg::DATA_W,
  parameter int ADDR_W = register_file_pkg::ADDR_W
) (
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs_i,
  input  logic [ADDR_W-1:0]                  raddr_i,
  input  logic                               wen_i,
  input  logic [ADDR_W-1:0]                  waddr_i,
  input  logic [DATA_W-1:0]                  wdata_i,
  output logic [DATA_W-1:0]                  rdata_o
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rdata_o = regs_i[raddr_i];
    if (wen_i && (waddr_i != ZERO_IDX) && (raddr_i == waddr_i)) begin
      rdata_o = wdata_i;
    end
    if (raddr_i == ZERO_IDX) begin
      rdata_o = '0;
    end
  end
`else
  // Without forwarding the write-side inputs have no consumer.
  logic w_unused;
  assign w_unused = ^{wen_i, waddr_i, wdata_i};

  always_comb begin
    rdata_o = regs_i[raddr_i];
    if (raddr_i == ZERO_IDX) begin
      rdata_o = '0;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/register_file.sv
// ============================================================================
// Module   : register_file
// Brief    : 32 x DATA_W register file, two combinational read ports, one
//            falling-edge write port, register 31 hard-wired to zero.
//            Define REGFILE_BYPASS_EN for write-through on the read ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_W = register_file_pkg::DATA_W,
  parameter int ADDR_W = register_file_pkg::ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [DATA_W-1:0] BusW,
  input  logic [ADDR_W-1:0] RW,
  input  logic              RegWr,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  output logic [DATA_W-1:0] BusA,
  output logic [DATA_W-1:0] BusB
);

  localparam int                DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0][DATA_W-1:0] regs_q;
  logic [DEPTH-1:0][DATA_W-1:0] regs_d;
  logic                         w_wen;

  // Reset also suppresses forwarding so the buses read zero during reset.
  assign w_wen = RegWr & Reset_n;

  always_comb begin
    regs_d = regs_q;
    if (RegWr && (RW != ZERO_IDX)) begin
      regs_d[RW] = BusW;
    end
  end

  // Writes land on the falling edge so a same-cycle read sees the old value.
  always_ff @(negedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port_a (
    .regs_i  (regs_q),
    .raddr_i (RA),
    .wen_i   (w_wen),
    .waddr_i (RW),
    .wdata_i (BusW),
    .rdata_o (BusA)
  );

  rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port_b (
    .regs_i  (regs_q),
    .raddr_i (RB),
    .wen_i   (w_wen),
    .waddr_i (RW),
    .wdata_i (BusW),
    .rdata_o (BusB)
  );

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// ============================================================================
// Module   : tb_register_file
// Brief    : Self-checking bench for register_file against an array model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_file;
  import register_file_pkg::*;

  localparam reg_addr_t XZR = reg_addr_t'(ZERO_REG);

  logic      Clk = 1'b1;
  logic      Reset_n;
  reg_data_t BusW;
  reg_addr_t RW;
  logic      RegWr;
  reg_addr_t RA;
  reg_addr_t RB;
  reg_data_t BusA;
  reg_data_t BusB;

  reg_data_t model [NUM_REGS];
  int        n_cmp = 0;
  int        n_err = 0;

  always #5 Clk = ~Clk;

  register_file dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .BusW    (BusW),
    .RW      (RW),
    .RegWr   (RegWr),
    .RA      (RA),
    .RB      (RB),
    .BusA    (BusA),
    .BusB    (BusB)
  );

  task automatic chk(input string tag, input reg_data_t obs, input reg_data_t exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic reg_data_t exp_rd(input reg_addr_t a);
    if (!Reset_n || a == XZR) return '0;
`ifdef REGFILE_BYPASS_EN
    if (RegWr && RW != XZR && a == RW) return BusW;
`endif
    return model[a];
  endfunction

  task automatic check_both(input string tag);
    chk({tag, "/A"}, BusA, exp_rd(RA));
    chk({tag, "/B"}, BusB, exp_rd(RB));
  endtask

  task automatic clear_model();
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
  endtask

  // Drive while Clk is high, check the pre-edge view, then the post-edge view.
  task automatic cycle(input logic wr, input reg_addr_t w, input reg_data_t d,
                       input reg_addr_t a, input reg_addr_t b, input string tag);
    @(posedge Clk);
    #1;
    RegWr = wr; RW = w; BusW = d; RA = a; RB = b;
    #1;
    check_both({tag, " pre"});
    @(negedge Clk);
    if (RegWr && Reset_n && RW != XZR) model[RW] = BusW;
    #1;
    check_both({tag, " post"});
  endtask

  task automatic reset_mid_cycle();
    @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    clear_model();
    RegWr = 1'b1; RW = 5'd5; BusW = 64'hDEAD_BEEF_0000_0005; RA = 5'd5; RB = reg_addr_t'($urandom);
    #1;
    check_both("async_rst");
    @(negedge Clk);
    #1;
    check_both("rst_blocks_wr");
    #2;
    Reset_n = 1'b1;
    #1;
    check_both("rst_release pre");
    @(negedge Clk);
    model[5] = BusW;
    #1;
    check_both("rst_release post");
    chk("rst_first_wr", BusA, 64'hDEAD_BEEF_0000_0005);
  endtask

  function automatic reg_addr_t rnd_addr();
    if ($urandom_range(0, 5) == 0) return XZR;
    return reg_addr_t'($urandom);
  endfunction

  initial begin
    clear_model();
    Reset_n = 1'b0;
    RegWr = 1'b1; RW = 5'd3; BusW = '1; RA = 5'd3; RB = XZR;
    @(negedge Clk);
    #1;
    check_both("in_reset");

    @(posedge Clk);
    #2;
    Reset_n = 1'b1;
    RegWr = 1'b0; RA = 5'd0; RB = 5'd1;
    #1;
    chk("rst_read/A", BusA, '0);
    chk("rst_read/B", BusB, '0);

    cycle(1'b1, XZR, 64'h1234_5678, XZR, XZR, "xzr_write");
    chk("xzr_read", BusA, '0);

    for (int i = 0; i < ZERO_REG; i++) begin
      cycle(1'b1, reg_addr_t'(i), reg_data_t'(i), reg_addr_t'(i), reg_addr_t'(ZERO_REG - i), "fill");
    end
    cycle(1'b0, 5'd1, 64'h1000, 5'd2, 5'd3, "hold");
    chk("fill_r2", BusA, 64'd2);
    chk("fill_r3", BusB, 64'd3);

    cycle(1'b1, 5'd13, 64'hABCD, 5'd0, 5'd13, "wr13");
    chk("wr13_after", BusB, 64'hABCD);

    cycle(1'b0, 5'd14, 64'h908_0009, 5'd14, 5'd14, "wr_disabled");
    chk("reg14_kept", BusA, 64'd14);

    cycle(1'b1, 5'd10, 64'h1010, 5'd6, 5'd7, "neighbours");
    chk("nb_r6", BusA, 64'd6);
    chk("nb_r7", BusB, 64'd7);
    RA = 5'd10;
    #1;
    chk("nb_r10", BusA, 64'h1010);

    for (int n = 0; n < 300; n++) begin
      reg_addr_t w;
      reg_addr_t a;
      reg_addr_t b;
      w = rnd_addr();
      a = ($urandom_range(0, 3) == 0) ? w : rnd_addr();
      b = ($urandom_range(0, 4) == 0) ? a : rnd_addr();
      cycle(1'($urandom), w, {$urandom, $urandom}, a, b, "rand");
      if (n == 150) reset_mid_cycle();
    end

    RegWr = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      RA = reg_addr_t'(i);
      RB = reg_addr_t'(NUM_REGS - 1 - i);
      #1;
      check_both("sweep");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_W, default 64, SHALL set the width of each register and of BusA/BusB/BusW.
REQ-002 Parameter ADDR_W, default 5, SHALL set the address width; depth SHALL be 2**ADDR_W (32).
REQ-003 Clk  input  1  SHALL be the single clock; the block has one clock and no other clock inputs.
REQ-004 Reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 BusW  input  DATA_W  SHALL carry the write data.
REQ-006 RW  input  ADDR_W  SHALL carry the write register index.
REQ-007 RegWr  input  1  SHALL be the write enable, active high.
REQ-008 RA  input  ADDR_W  SHALL carry the read index for port A.
REQ-009 RB  input  ADDR_W  SHALL carry the read index for port B.
REQ-010 BusA  output  DATA_W  SHALL drive the read data for port A.
REQ-011 BusB  output  DATA_W  SHALL drive the read data for port B.

Function
REQ-012 Storage SHALL be 32 registers x DATA_W bits.
REQ-013 Reads SHALL be combinational: BusA = reg[RA] and BusB = reg[RB], with no clock latency.
REQ-014 Register 31 SHALL be the zero register (XZR): reads of index 31 SHALL always return 0.
REQ-015 A write to index 31 SHALL be discarded.
REQ-016 Register 0 SHALL be an ordinary writable register.
REQ-017 Writes SHALL occur on the falling edge of Clk when RegWr=1: reg[RW] <= BusW.
REQ-018 When RegWr=0, no register SHALL change at the falling edge.
REQ-019 Rising edges of Clk SHALL have no effect.
REQ-020 While a write is pending (before the falling edge), reads of RW SHALL return the old value; the new value SHALL appear on the read buses immediately after the falling edge.
REQ-021 RA, RB and RW SHALL be fully independent.
REQ-022 RA = RB SHALL drive the same value on both buses.
REQ-023 Only register RW SHALL change on a write; all other registers SHALL hold their values.

Reset
REQ-024 Reset_n=0 SHALL asynchronously clear registers 0..30 to 0, independent of Clk.
REQ-025 While Reset_n=0, writes SHALL be blocked, and BusA/BusB SHALL read 0 for every index.
REQ-026 If Reset_n deasserts between falling edges, the first write SHALL take effect at the next falling edge.

Configuration
REQ-027 Macro REGFILE_BYPASS_EN SHALL enable write-through: when it is defined and RegWr=1, RW!=31 and RA==RW (respectively RB==RW), BusA (respectively BusB) SHALL return BusW combinationally.
REQ-028 When REGFILE_BYPASS_EN is undefined (the default), REQ-020 behaviour SHALL hold and there SHALL be no forwarding path.

Structure
REQ-029 Package register_file_pkg SHALL hold DATA_W, ADDR_W, NUM_REGS=32 and ZERO_REG=31, together with the typedefs reg_data_t and reg_addr_t.
REQ-030 One sub-module, rf_read_port, SHALL be used: a 32:1 read mux with zero-register masking and optional bypass, instantiated twice (ports A and B).

Verification
REQ-031 Reset then read: pulse Reset_n low, then set RA=0 and RB=1 -> BusA=0 and BusB=0.
REQ-032 Zero register: RW=31, BusW=0x12345678, RegWr=1, then a falling edge; RA=RB=31 -> both buses read 0 before and after the edge.
REQ-033 Fill: write reg[i]=i for i=0..30, one falling edge each; then RA=2, RB=3 -> BusA=2 and BusB=3, and the values hold across a further edge with RegWr=0 and RW=1, BusW=0x1000.
REQ-034 Write timing: RB=13, RW=13, BusW=0xABCD, RegWr=1 -> BusB=13 before the falling edge and 0xABCD after it (bypass macro undefined).
REQ-035 Disabled write: RW=14, BusW=0x9080009, RegWr=0, then an edge -> reg14 still reads 14.
REQ-036 Unaffected neighbours: write RW=10 with 0x1010 while RA=6, RB=7 -> BusA=6 and BusB=7; then RA=10 -> BusA=0x1010.
